// File: rtl/hash_pkg.sv
// Shared sizing constants and sequencer state encoding for the hash ROM lookup path.
// Contains no logic, only types and constants.
package hash_pkg;

    localparam int HASH_DEPTH = 8;
    localparam int HASH_AW    = 3;
    localparam int HASH_DW    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } hash_state_e;

endpackage

// File: rtl/hash_match_ctrl.sv
// Scans hash_rom for a latched candidate. Done arrives k+2 cycles after accept on an early hit at k, otherwise DEPTH+1.
// No backpressure: start is sampled only in IDLE, and a start seen while busy is dropped rather than queued.
module hash_match_ctrl
    import hash_pkg::*;
#(
    parameter int DEPTH      = HASH_DEPTH,
    parameter int AW         = HASH_AW,
    parameter int DW         = HASH_DW,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] candidate,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic          busy,
    output logic          done,
    output logic          match,
    output logic [AW-1:0] match_idx
);

    hash_state_e   state_q, state_d;
    logic [DW-1:0] cand_q, cand_d;
    logic [AW-1:0] addr_d, idx_d;
    logic          match_d, found_q, found_d, hit, last;

    assign busy = (state_q == SCAN);
    assign done = (state_q == DONE);
    assign hit  = (rom_data == cand_q);
    assign last = (rom_addr == AW'(DEPTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rom_addr  <= '0;
            match     <= 1'b0;
            match_idx <= '0;
            cand_q    <= '0;
            found_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rom_addr  <= addr_d;
            match     <= match_d;
            match_idx <= idx_d;
            cand_q    <= cand_d;
            found_q   <= found_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = rom_addr;
        match_d = match;
        idx_d   = match_idx;
        cand_d  = cand_q;
        found_d = found_q;
        case (state_q)
            IDLE: begin
                addr_d = '0;
                if (start) begin
                    cand_d  = candidate;
                    match_d = 1'b0;
                    idx_d   = '0;
                    found_d = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (hit && EARLY_EXIT) begin
                    match_d = 1'b1;
                    idx_d   = rom_addr;
                    addr_d  = '0;
                    state_d = DONE;
                end else begin
                    // Constant-time mode: first hit wins, so the lowest index is reported.
                    if (hit && !found_q) begin
                        match_d = 1'b1;
                        idx_d   = rom_addr;
                        found_d = 1'b1;
                    end
                    if (last) begin
                        addr_d  = '0;
                        state_d = DONE;
                    end else begin
                        addr_d = rom_addr + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase
    end

endmodule

// File: doc/hash_match_ctrl.md
Name: hash_match_ctrl

Overview:
- Sequencer that scans the 8-entry, 32-bit hash ROM (hash_rom) for a candidate hash value.
- Accepts a start request with a 32-bit candidate and drives the ROM address through entries 0..DEPTH-1. Compares each returned ROM word against the latched candidate.
- Reports match/no-match and the matching index with a one-cycle done pulse.
- Sits between the password/entry logic and the ROM. The ROM stays a separate combinational block; this block owns its address bus.

Parameters:
- DEPTH, 8, number of ROM entries scanned (power of two).
- AW, 3, ROM address width, equal to log2(DEPTH).
- DW, 32, hash word width.
- EARLY_EXIT, 1:
  - 1: stop at the first match.
  - 0: always scan all entries (constant-time), reporting the lowest matching index.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a scan; sampled only in IDLE
- candidate  in  DW  hash to look up; latched on the accepted start
- rom_addr  out  AW  address to hash_rom; registered
- rom_data  in  DW  combinational data from hash_rom for the current rom_addr
- busy  out  1  high from the cycle after start is accepted through the last SCAN cycle
- done  out  1  one-cycle pulse when the result is valid
- match  out  1  result flag; held until the next accepted start
- match_idx  out  AW  index of the matching entry; 0 when match=0; held

Behaviour:
- Reset (async, active-high): state=IDLE; rom_addr=0, busy=0, done=0, match=0, match_idx=0, cand_q=0. Reset mid-scan aborts the scan immediately with no done pulse.
- States: IDLE, SCAN, DONE.
- IDLE:
  - busy=0, done=0, rom_addr held at 0.
  - start=1 causes, at the edge: cand_q<=candidate, rom_addr<=0, match<=0, match_idx<=0, found_q<=0, state<=SCAN.
- SCAN (busy=1): each cycle compares rom_data (for the current rom_addr) with cand_q using full DW-bit equality.
  - Hit with EARLY_EXIT=1: match<=1, match_idx<=rom_addr, state<=DONE.
  - Hit with EARLY_EXIT=0 and found_q=0: record match<=1, match_idx<=rom_addr, found_q<=1, then keep scanning. Later hits do not overwrite, so the lowest index is reported.
  - Terminal condition: if rom_addr==DEPTH-1 and no early exit, state<=DONE with match/match_idx as recorded. Otherwise rom_addr<=rom_addr+1.
  - rom_addr never wraps inside a scan. It returns to 0 on entry to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then state<=IDLE unconditionally.
- start handling outside IDLE:
  - start in SCAN or DONE is ignored; it is not queued.
  - start held high continuously gives back-to-back scans with one IDLE cycle between them.
- Latency, with the start-accept cycle as cycle 0:
  - EARLY_EXIT=1, hit at index k: done in cycle k+2.
  - Miss, or EARLY_EXIT=0: done in cycle DEPTH+1 (cycle 9 for DEPTH=8).
- Candidate changes after acceptance have no effect, because only cand_q is used.
- Candidate 0 is not special. It matches only if a ROM entry is 0.

Decomposition:
- Shared package hash_pkg holds:
  - HASH_DEPTH=8, HASH_AW=3, HASH_DW=32;
  - the state enum {IDLE, SCAN, DONE}, 2-bit encoding.
- Sub-modules: none. This is a single FSM plus address counter and compare.
- hash_rom is instantiated alongside it by the parent, and in the bench, not inside this block.

Test Plan:
- Reset, then start with candidate=32'hDC1A2C9E -> match=1, match_idx=0, done in cycle 2, busy high only in cycle 1.
- Start with candidate=32'h9948E6BE -> match=1, match_idx=7, done in cycle 9, rom_addr steps 0..7 with no wrap.
- Start with candidate=32'h00000000 -> match=0, match_idx=0, done in cycle 9; the previous match result is cleared at acceptance.
- Start with candidate=32'h355FACC3; pulse start again with 32'hDC1A2C9E in cycles 1 and 3 -> second request ignored; result match_idx=2, done in cycle 4.
- Start with candidate=32'h7EBCF8A8, assert reset in cycle 3 -> all outputs 0 immediately, no done pulse. A post-reset start with the same candidate gives match_idx=5, done in cycle 7.
- EARLY_EXIT=0, candidate=32'hAAF4ADC9 -> match=1, match_idx=3, done in cycle 9 (constant time); candidate=32'h12345678 -> match=0, done in cycle 9.
